// File: rtl/flit_receiver_if.sv
// Handshake bundle for the flit receiver: a byte stream enters, assembled flits leave.
// The receiver uses the slave modport; whoever feeds bytes and takes flits uses master.
interface flit_receiver_if #(
  parameter int FLIT_BYTES = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [7:0]              in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [FLIT_BYTES*8-1:0] out_flit;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_flit
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_flit
  );
endinterface

// File: rtl/flit_receiver.sv
// Byte-to-flit receiver: assembles FLIT_BYTES-byte flits, checks the additive
// checksum, drops partial flits on an inter-byte timeout, and holds good flits for the packet layer.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_RECV | collecting bytes; in_ready=1; inter-byte timer runs mid-flit
// S_HOLD | good flit presented; in_ready=0, out_valid=1; no timeout
module flit_receiver #(
  parameter int FLIT_BYTES     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst,
  flit_receiver_if.slave bus,
  output logic           err_checksum,
  output logic           err_timeout,
  output logic [15:0]    good_count
);

  localparam int IDX_W = $clog2(FLIT_BYTES);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FLIT_BYTES - 1);
  // Expiry is decided in the idle cycle that would bring the count to TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    S_RECV = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [7:0]              sum_q, sum_d;
  logic [CNT_W-1:0]        tmo_q, tmo_d;
  logic [FLIT_BYTES*8-1:0] flit_q, flit_d;
  logic                    err_cks_q, err_cks_d;
  logic                    err_tmo_q, err_tmo_d;
  logic [15:0]             good_q, good_d;

  logic                    accept;
  logic [7:0]              sum_next;
  logic                    last_byte;
  logic                    flit_good;

  assign bus.in_ready  = (state_q == S_RECV) && !rst;
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.out_flit  = flit_q;
  assign err_checksum  = err_cks_q;
  assign err_timeout   = err_tmo_q;
  assign good_count    = good_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign sum_next  = sum_q + bus.in_data;
  assign last_byte = (idx_q == LAST_IDX);
  assign flit_good = (sum_next == 8'h00);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    tmo_d     = tmo_q;
    flit_d    = flit_q;
    good_d    = good_q;
    err_cks_d = 1'b0;
    err_tmo_d = 1'b0;

    unique case (state_q)
      S_RECV: begin
        if (accept) begin
          flit_d[idx_q*8 +: 8] = bus.in_data;
          tmo_d                = '0;
          if (last_byte) begin
            idx_d = '0;
            sum_d = 8'h00;
            if (flit_good) begin
              state_d = S_HOLD;
            end else begin
              err_cks_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
            sum_d = sum_next;
          end
        end else if (idx_q == '0) begin
          tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
          idx_d     = '0;
          sum_d     = 8'h00;
          tmo_d     = '0;
          err_tmo_d = 1'b1;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (bus.out_ready) begin
          state_d = S_RECV;
          good_d  = good_q + 16'd1;
        end
      end

      default: state_d = S_RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RECV;
      idx_q     <= '0;
      sum_q     <= 8'h00;
      tmo_q     <= '0;
      flit_q    <= '0;
      err_cks_q <= 1'b0;
      err_tmo_q <= 1'b0;
      good_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      tmo_q     <= tmo_d;
      flit_q    <= flit_d;
      err_cks_q <= err_cks_d;
      err_tmo_q <= err_tmo_d;
      good_q    <= good_d;
    end
  end

endmodule

// File: tb/tb_flit_receiver.sv
// Directed bench for flit_receiver (FLIT_BYTES=8, TIMEOUT_CYCLES=16) with
// hand-computed flits: good, bad checksum, timeout, timeout boundary, backpressure, reset.
module tb_flit_receiver;

  localparam logic [63:0] GOOD  = 64'hE407060504030201;
  localparam logic [63:0] BAD   = 64'hE507060504030201;
  localparam logic [63:0] GOOD2 = 64'h4070605040302010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_checksum;
  logic        err_timeout;
  logic [15:0] good_count;

  int n_checks = 0;
  int n_errors = 0;
  int cks_seen = 0;
  int tmo_seen = 0;
  int exp_good = 0;
  int c0, t0;

  flit_receiver_if #(.FLIT_BYTES(8)) bus ();

  flit_receiver #(
    .FLIT_BYTES    (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err_checksum(err_checksum),
    .err_timeout (err_timeout),
    .good_count  (good_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (err_checksum) cks_seen++;
    if (err_timeout)  tmo_seen++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    while (!bus.in_ready && n < 40) begin
      n++;
      @(posedge clk);
    end
    if (n >= 40) chk("accept_wait", 64'd0, 64'd1);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [63:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) send_byte(f[8*i +: 8]);
  endtask

  // Present at t+1 after the last byte; take it this cycle with out_ready=1.
  task automatic expect_flit(input string tag, input logic [63:0] f);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_flit"}, bus.out_flit, f);
    chk({tag, "_inrdy_hold"}, 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    cycles(1);
    exp_good++;
    chk({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_inrdy_back"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_count"}, 64'(good_count), 64'(exp_good));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;

    // reset state
    cycles(3);
    chk("rst_inrdy", 64'(bus.in_ready), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_flit", bus.out_flit, 64'd0);
    chk("rst_count", 64'(good_count), 64'd0);
    chk("rst_errs", 64'({err_checksum, err_timeout}), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_inrdy", 64'(bus.in_ready), 64'd1);
    cycles(2);

    // good flit
    send_bytes(GOOD, 0, 7);
    expect_flit("good", GOOD);
    chk("good_noerr", 64'(cks_seen + tmo_seen), 64'd0);

    // bad checksum, followed back-to-back by a good flit
    c0 = cks_seen;
    send_bytes(BAD, 0, 7);
    chk("bad_pulse", 64'(err_checksum), 64'd1);
    chk("bad_novalid", 64'(bus.out_valid), 64'd0);
    chk("bad_inrdy", 64'(bus.in_ready), 64'd1);
    chk("bad_count", 64'(good_count), 64'(exp_good));
    send_bytes(GOOD, 0, 7);
    chk("bad_once", 64'(cks_seen - c0), 64'd1);
    chk("bad_nopulse_after", 64'(err_checksum), 64'd0);
    expect_flit("after_bad", GOOD);

    // timeout after 16 idle cycles
    t0 = tmo_seen;
    send_bytes(GOOD, 0, 2);
    cycles(15);
    chk("tmo_early", 64'(err_timeout), 64'd0);
    cycles(1);
    chk("tmo_pulse", 64'(err_timeout), 64'd1);
    send_bytes(GOOD, 0, 7);
    chk("tmo_once", 64'(tmo_seen - t0), 64'd1);
    expect_flit("after_tmo", GOOD);

    // byte on the 16th idle-counting cycle wins over expiry
    t0 = tmo_seen;
    send_bytes(GOOD, 0, 2);
    cycles(15);
    send_bytes(GOOD, 3, 7);
    chk("bnd_notmo", 64'(tmo_seen - t0), 64'd0);
    expect_flit("bnd", GOOD);

    // backpressure with in_valid held high
    t0 = tmo_seen;
    bus.out_ready = 1'b0;
    send_bytes(GOOD2, 0, 7);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      chk("bp_inrdy", 64'(bus.in_ready), 64'd0);
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_flit", bus.out_flit, GOOD2);
      cycles(1);
    end
    bus.in_valid = 1'b0;
    chk("bp_notmo", 64'(tmo_seen - t0), 64'd0);
    expect_flit("bp", GOOD2);

    // reset mid-flit
    c0 = cks_seen;
    t0 = tmo_seen;
    send_bytes(GOOD, 0, 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_inrdy", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_good = 0;
    chk("mid_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_flit", bus.out_flit, 64'd0);
    chk("mid_count", 64'(good_count), 64'd0);
    chk("mid_errs", 64'({err_checksum, err_timeout}), 64'd0);
    cycles(20);
    send_bytes(GOOD, 0, 7);
    expect_flit("mid_new", GOOD);
    chk("mid_nopulse", 64'((cks_seen - c0) + (tmo_seen - t0)), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
